conv_unit_gen: RTL

CONV_UNIT_GEN -- requirements
Module: conv_unit_gen

---
 rtl/conv_unit_gen.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/conv_unit_gen.sv
// Convolution unit: per-channel window MAC over FILTERS_PER_UNIT filters, bias + accumulate, saturating output.
// Optional ReLU on the output stage is compiled in with macro CONV_UNIT_GEN_RELU_EN.
module conv_unit_gen #(
    parameter int DATA_WIDTH       = 32,
    parameter int FRAC_BITS        = 16,
    parameter int KERNAL_SIZE      = 5,
    parameter int IFM_DEPTH        = 3,
    parameter int FILTERS_PER_UNIT = 2
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   wm_wr_en,
    input  logic [$clog2(FILTERS_PER_UNIT*IFM_DEPTH*KERNAL_SIZE*KERNAL_SIZE)-1:0] wm_wr_addr,
    input  logic                                                   bias_wr_en,
    input  logic [((FILTERS_PER_UNIT > 1) ? $clog2(FILTERS_PER_UNIT) : 1)-1:0] bias_wr_sel,
    input  logic [DATA_WIDTH-1:0]                                  riscv_data,
    output logic                                                   wr_err,
    input  logic                                                   win_valid,
    output logic                                                   win_ready,
    input  logic [KERNAL_SIZE*KERNAL_SIZE*DATA_WIDTH-1:0]          win_data,
    input  logic                                                   relu_enable,
    output logic                                                   out_valid,
    input  logic                                                   out_ready,
    output logic [DATA_WIDTH-1:0]                                  out_data,
    output logic [((FILTERS_PER_UNIT > 1) ? $clog2(FILTERS_PER_UNIT) : 1)-1:0] out_filter,
    output logic                                                   busy
);

    localparam int KK       = KERNAL_SIZE * KERNAL_SIZE;
    localparam int WM_DEPTH = FILTERS_PER_UNIT * IFM_DEPTH * KK;
    localparam int FS_W     = (FILTERS_PER_UNIT > 1) ? $clog2(FILTERS_PER_UNIT) : 1;
    localparam int CH_W     = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1;
    localparam int PW       = 2 * DATA_WIDTH;
    localparam int ACC_W    = PW + $clog2(KK * IFM_DEPTH + 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;

    state_t                         state_q, state_d;
    logic [FS_W-1:0]                fcnt_q, fcnt_d;
    logic [FS_W-1:0]                ocnt_q, ocnt_d;
    logic [CH_W-1:0]                ch_q, ch_d;
    logic signed [ACC_W-1:0]        acc_q [FILTERS_PER_UNIT];
    logic signed [ACC_W-1:0]        acc_d [FILTERS_PER_UNIT];
    logic [DATA_WIDTH-1:0]          win_q [KK];
    logic [DATA_WIDTH-1:0]          win_d [KK];
    logic [DATA_WIDTH-1:0]          wmem_q [WM_DEPTH];
    logic [DATA_WIDTH-1:0]          wmem_d [WM_DEPTH];
    logic [DATA_WIDTH-1:0]          bias_q [FILTERS_PER_UNIT];
    logic [DATA_WIDTH-1:0]          bias_d [FILTERS_PER_UNIT];
    logic                           out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]          out_data_q, out_data_d;
    logic [FS_W-1:0]                out_filter_q, out_filter_d;
    logic                           wr_err_q, wr_err_d;

    logic signed [ACC_W-1:0]        s_sum;
    logic signed [PW-1:0]           a_ext, b_ext, prod;
    int unsigned                    w_idx;
    logic [DATA_WIDTH-1:0]          cur_bias;
    logic                           wm_addr_ok, bias_sel_ok;

    assign busy       = (state_q != IDLE) || (ch_q != '0);
    assign win_ready  = (state_q == IDLE) && !reset;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_filter = out_filter_q;
    assign wr_err     = wr_err_q;

`ifndef CONV_UNIT_GEN_RELU_EN
    logic unused_relu;
    assign unused_relu = relu_enable;
`endif

    function automatic logic [DATA_WIDTH-1:0] post_proc(input logic signed [ACC_W-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        if (v > SAT_MAX)      r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (v < SAT_MIN) r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else                  r = v[DATA_WIDTH-1:0];
`ifdef CONV_UNIT_GEN_RELU_EN
        if (relu_enable && r[DATA_WIDTH-1]) r = '0;
`endif
        return r;
    endfunction

    // Each product is scaled back to FRAC_BITS before summing, so truncation happens per tap.
    always_comb begin
        s_sum = '0;
        a_ext = '0;
        b_ext = '0;
        prod  = '0;
        w_idx = 0;
        for (int unsigned k = 0; k < KK; k++) begin
            w_idx = (32'(fcnt_q) * IFM_DEPTH + 32'(ch_q)) * KK + k;
            a_ext = {{DATA_WIDTH{win_q[k][DATA_WIDTH-1]}}, win_q[k]};
            b_ext = {{DATA_WIDTH{wmem_q[w_idx][DATA_WIDTH-1]}}, wmem_q[w_idx]};
            prod  = (a_ext * b_ext) >>> FRAC_BITS;
            s_sum = s_sum + {{(ACC_W-PW){prod[PW-1]}}, prod};
        end
    end

    always_comb begin
        wm_addr_ok  = 32'(wm_wr_addr) < WM_DEPTH;
        bias_sel_ok = 32'(bias_wr_sel) < FILTERS_PER_UNIT;
        wmem_d      = wmem_q;
        bias_d      = bias_q;
        if (wm_wr_en && !busy && wm_addr_ok)     wmem_d[wm_wr_addr] = riscv_data;
        if (bias_wr_en && !busy && bias_sel_ok)  bias_d[bias_wr_sel] = riscv_data;
        wr_err_d = (wm_wr_en && (busy || !wm_addr_ok)) || (bias_wr_en && (busy || !bias_sel_ok));
    end

    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        ocnt_d       = ocnt_q;
        ch_d         = ch_q;
        acc_d        = acc_q;
        win_d        = win_q;
        out_data_d   = out_data_q;
        out_filter_d = out_filter_q;
        cur_bias     = bias_q[fcnt_q];
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    for (int unsigned k = 0; k < KK; k++)
                        win_d[k] = win_data[k*DATA_WIDTH +: DATA_WIDTH];
                    state_d = COMPUTE;
                    fcnt_d  = '0;
                end
            end
            COMPUTE: begin
                acc_d[fcnt_q] = ((ch_q == '0) ? {{(ACC_W-DATA_WIDTH){cur_bias[DATA_WIDTH-1]}}, cur_bias}
                                              : acc_q[fcnt_q]) + s_sum;
                if (fcnt_q == FS_W'(FILTERS_PER_UNIT-1)) begin
                    if (ch_q == CH_W'(IFM_DEPTH-1)) begin
                        state_d = OUTPUT;
                        ocnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                        ch_d    = ch_q + 1'b1;
                    end
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    if (ocnt_q == FS_W'(FILTERS_PER_UNIT-1)) begin
                        state_d = IDLE;
                        ch_d    = '0;
                    end else begin
                        ocnt_d = ocnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Output registers are loaded from next-state values so they are valid on the first OUTPUT cycle.
        out_valid_d = (state_d == OUTPUT);
        if (state_d == OUTPUT) begin
            out_filter_d = ocnt_d;
            out_data_d   = post_proc(acc_d[ocnt_d]);
        end
    end

    always_ff @(posedge clk) begin
        wmem_q <= wmem_d;
        bias_q <= bias_d;
        if (reset) begin
            state_q      <= IDLE;
            fcnt_q       <= '0;
            ocnt_q       <= '0;
            ch_q         <= '0;
            acc_q        <= '{default: '0};
            win_q        <= '{default: '0};
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_filter_q <= '0;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            ocnt_q       <= ocnt_d;
            ch_q         <= ch_d;
            acc_q        <= acc_d;
            win_q        <= win_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_filter_q <= out_filter_d;
            wr_err_q     <= wr_err_d;
        end
    end

endmodule
